// File: rtl/flash_ctrl_fsm.sv
// Bus-side controller for a 16-bit NOR flash: two-halfword reads into a 32-bit word,
// and either a full program/poll/restore sequence or a single raw halfword write.
module flash_ctrl_fsm #(
  parameter int ADDR_W       = 22,
  parameter int RD_WAIT      = 3,
  parameter int WR_WAIT      = 3,
  parameter int AUTO_PROGRAM = 1,
  parameter int POLL_MAX     = 65535
) (
  input  logic              clk_bus,
  input  logic              rst,
  input  logic [23:0]       bus_address,
  input  logic [31:0]       bus_data_i,
  output logic [31:0]       bus_data_o,
  input  logic              bus_read,
  input  logic              bus_write,
  output logic              bus_stall,
  output logic              bus_err,
  output logic [ADDR_W-1:0] flash_address,
  inout  wire  [15:0]       flash_data,
  output logic              flash_we_n,
  output logic              flash_oe_n,
  output logic              flash_ce_n,
  output logic              flash_rp_n,
  output logic              flash_byte_n,
  output logic              flash_vpen
);

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI, WR_CMD, WR_REC1, WR_DATA, WR_REC2,
    POLL, POLL_REC, WR_FF, WR_REC3, DONE
  } state_t;

  localparam int MAXW = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int PW   = $clog2(POLL_MAX + 1);

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [PW-1:0]     r_poll;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wdata;
  logic [15:0]       r_latched;
  logic              r_drive;
  logic              r_we_n;
  logic              r_oe_n;
  logic              r_ce_n;
  logic              r_rp_n;
  logic [31:0]       r_data_o;
  logic              r_err;

  logic w_rd_last;
  logic w_wr_last;
  logic w_unused;

  assign w_rd_last = (r_cnt == CW'(RD_WAIT - 1));
  assign w_wr_last = (r_cnt == CW'(WR_WAIT - 1));
  assign w_unused  = &{1'b0, bus_data_i[31:16], bus_address[23], bus_address[0]};

  always_ff @(posedge clk_bus or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_poll    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_latched <= '0;
      r_drive   <= 1'b0;
      r_we_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_ce_n    <= 1'b1;
      r_rp_n    <= 1'b0;
      r_data_o  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rp_n <= 1'b1;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus_read) begin
            r_addr  <= {bus_address[ADDR_W:2], 1'b0};
            r_ce_n  <= 1'b0;
            r_oe_n  <= 1'b0;
            r_state <= RD_LO;
          end else if (bus_write) begin
            r_addr    <= {bus_address[ADDR_W:2], bus_address[1]};
            r_latched <= bus_data_i[15:0];
            r_poll    <= '0;
            r_ce_n    <= 1'b0;
            r_we_n    <= 1'b0;
            r_drive   <= 1'b1;
            if (AUTO_PROGRAM != 0) begin
              r_wdata <= 16'h0040;
              r_state <= WR_CMD;
            end else begin
              r_wdata <= bus_data_i[15:0];
              r_state <= WR_DATA;
            end
          end
        end
        RD_LO: begin
          if (w_rd_last) begin
            r_cnt            <= '0;
            r_data_o[15:0]   <= flash_data;
            r_addr           <= r_addr + 1'b1;
            r_state          <= RD_HI;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RD_HI: begin
          if (w_rd_last) begin
            r_cnt           <= '0;
            r_data_o[31:16] <= flash_data;
            r_err           <= 1'b0;
            r_oe_n          <= 1'b1;
            r_ce_n          <= 1'b1;
            r_state         <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WR_CMD, WR_DATA, WR_FF: begin
          if (w_wr_last) begin
            r_cnt   <= '0;
            r_we_n  <= 1'b1;
            r_state <= (r_state == WR_CMD)  ? WR_REC1 :
                       (r_state == WR_DATA) ? WR_REC2 : WR_REC3;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WR_REC1: begin
          r_we_n  <= 1'b0;
          r_wdata <= r_latched;
          r_state <= WR_DATA;
        end
        WR_REC2: begin
          r_drive <= 1'b0;
          if (AUTO_PROGRAM != 0) begin
            r_oe_n  <= 1'b0;
            r_state <= POLL;
          end else begin
            r_ce_n  <= 1'b1;
            r_state <= DONE;
          end
        end
        POLL: begin
          if (w_rd_last) begin
            r_cnt  <= '0;
            r_poll <= r_poll + 1'b1;
            r_oe_n <= 1'b1;
            // A completed status (SR7) wins over the timeout on the same poll.
            if (flash_data[7] || (r_poll == PW'(POLL_MAX - 1))) begin
              if (!flash_data[7] || flash_data[4] || flash_data[3]) begin
                r_err <= 1'b1;
              end
              r_we_n  <= 1'b0;
              r_drive <= 1'b1;
              r_wdata <= 16'h00FF;
              r_state <= WR_FF;
            end else begin
              r_state <= POLL_REC;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        POLL_REC: begin
          r_oe_n  <= 1'b0;
          r_state <= POLL;
        end
        WR_REC3: begin
          r_drive <= 1'b0;
          r_ce_n  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus_stall     = (bus_read | bus_write) & (r_state != DONE);
  assign bus_data_o    = r_data_o;
  assign bus_err       = r_err;
  assign flash_address = r_addr;
  assign flash_data    = r_drive ? r_wdata : 16'hzzzz;
  assign flash_we_n    = r_we_n;
  assign flash_oe_n    = r_oe_n;
  assign flash_ce_n    = r_ce_n;
  assign flash_rp_n    = r_rp_n;
  assign flash_byte_n  = 1'b1;
  assign flash_vpen    = 1'b1;

endmodule

// File: tb/tb_flash_ctrl_fsm.sv
// Self-checking bench for flash_ctrl_fsm: three instances (default, short poll limit,
// raw write mode) share one behavioural flash model; writes are scoreboarded.
module tb_flash_ctrl_fsm;

  logic clk_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  logic        rst;
  logic [23:0] baddr;
  logic [31:0] bdin;
  logic        rd     [3];
  logic        wr     [3];
  logic        stall  [3];
  logic        err    [3];
  logic        we_n   [3];
  logic        oe_n   [3];
  logic        ce_n   [3];
  logic        rp_n   [3];
  logic        byte_n [3];
  logic        vpen   [3];
  logic [31:0] dout   [3];
  logic [21:0] fa     [3];
  wire  [15:0] fd0, fd1, fd2;

  flash_ctrl_fsm #(.ADDR_W(22), .RD_WAIT(3), .WR_WAIT(3), .AUTO_PROGRAM(1), .POLL_MAX(65535)) u_dut (
    .clk_bus(clk_bus), .rst(rst), .bus_address(baddr), .bus_data_i(bdin), .bus_data_o(dout[0]),
    .bus_read(rd[0]), .bus_write(wr[0]), .bus_stall(stall[0]), .bus_err(err[0]),
    .flash_address(fa[0]), .flash_data(fd0), .flash_we_n(we_n[0]), .flash_oe_n(oe_n[0]),
    .flash_ce_n(ce_n[0]), .flash_rp_n(rp_n[0]), .flash_byte_n(byte_n[0]), .flash_vpen(vpen[0]));

  flash_ctrl_fsm #(.ADDR_W(22), .RD_WAIT(3), .WR_WAIT(3), .AUTO_PROGRAM(1), .POLL_MAX(4)) u_dut_to (
    .clk_bus(clk_bus), .rst(rst), .bus_address(baddr), .bus_data_i(bdin), .bus_data_o(dout[1]),
    .bus_read(rd[1]), .bus_write(wr[1]), .bus_stall(stall[1]), .bus_err(err[1]),
    .flash_address(fa[1]), .flash_data(fd1), .flash_we_n(we_n[1]), .flash_oe_n(oe_n[1]),
    .flash_ce_n(ce_n[1]), .flash_rp_n(rp_n[1]), .flash_byte_n(byte_n[1]), .flash_vpen(vpen[1]));

  flash_ctrl_fsm #(.ADDR_W(22), .RD_WAIT(3), .WR_WAIT(3), .AUTO_PROGRAM(0), .POLL_MAX(65535)) u_dut_raw (
    .clk_bus(clk_bus), .rst(rst), .bus_address(baddr), .bus_data_i(bdin), .bus_data_o(dout[2]),
    .bus_read(rd[2]), .bus_write(wr[2]), .bus_stall(stall[2]), .bus_err(err[2]),
    .flash_address(fa[2]), .flash_data(fd2), .flash_we_n(we_n[2]), .flash_oe_n(oe_n[2]),
    .flash_ce_n(ce_n[2]), .flash_rp_n(rp_n[2]), .flash_byte_n(byte_n[2]), .flash_vpen(vpen[2]));

  // Flash model: array memory, 0x40 program setup, status mode until 0xFF.
  logic [15:0] mem      [1024];
  logic        mode     [3];
  logic        pend     [3];
  logic        prev_we  [3];
  logic        prev_oe  [3];
  int          polls    [3];
  int          oefall   [3];
  int          ready_at [3];
  logic [15:0] sr_done  [3];
  logic        men      [3];
  logic [15:0] mval     [3];
  logic [39:0] obs_log  [256];
  int          obs_n;
  int          viol;
  bit          loaded;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      men[i]  = 1'b0;
      mval[i] = 16'h0000;
      men[i]  = !oe_n[i] && !ce_n[i];
      if (mode[i]) mval[i] = (polls[i] >= ready_at[i]) ? sr_done[i] : 16'h0000;
      else         mval[i] = mem[fa[i][9:0]];
    end
  end

  assign fd0 = men[0] ? mval[0] : 16'hzzzz;
  assign fd1 = men[1] ? mval[1] : 16'hzzzz;
  assign fd2 = men[2] ? mval[2] : 16'hzzzz;

  always @(negedge clk_bus) begin
    logic [15:0] w;
    if (!loaded) begin
      for (int a = 0; a < 1024; a++) mem[a] = 16'h0000;
      mem[256] = 16'h1234;
      mem[257] = 16'hABCD;
      loaded = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mode[i] = 1'b0; pend[i] = 1'b0; prev_we[i] = 1'b1; prev_oe[i] = 1'b1; polls[i] = 0;
      end else begin
        w = (i == 0) ? fd0 : (i == 1) ? fd1 : fd2;
        if (!oe_n[i] && !we_n[i]) viol++;
        if (prev_oe[i] && !oe_n[i]) begin
          oefall[i]++;
          if (mode[i]) polls[i]++;
        end
        if (!prev_we[i] && we_n[i] && !ce_n[i]) begin
          if (obs_n < 256) obs_log[obs_n] = {2'(i), fa[i], w};
          obs_n++;
          if (pend[i]) begin
            mem[fa[i][9:0]] = w; pend[i] = 1'b0; mode[i] = 1'b1; polls[i] = 0;
          end else if (w == 16'h0040) begin
            pend[i] = 1'b1;
          end else if (w == 16'h00FF) begin
            mode[i] = 1'b0;
          end
        end
        prev_we[i] = we_n[i];
        prev_oe[i] = oe_n[i];
      end
    end
  end

  int          n_cmp;
  int          n_bad;
  int          obs_rd;
  logic [39:0] expq [$];
  logic [31:0] rexp [$];

  task automatic start_req(input int inst, input bit r, input bit w, input logic [23:0] a, input logic [31:0] d);
    baddr = a; bdin = d; rd[inst] = r; wr[inst] = w;
  endtask

  task automatic end_req(input int inst);
    rd[inst] = 1'b0; wr[inst] = 1'b0;
  endtask

  task automatic wait_done(input int inst, output int cyc, output bit to);
    cyc = 0; to = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      #1;
      if (!stall[inst]) begin to = 1'b0; break; end
      cyc++;
      @(negedge clk_bus);
    end
  endtask

  task automatic next_obs(output logic [39:0] v);
    if (obs_rd < obs_n) v = obs_log[obs_rd];
    else v = 40'hFF_FFFF_FFFF;
    obs_rd++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk_bus);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({we_n[i], oe_n[i], ce_n[i], rp_n[i], byte_n[i], vpen[i]} !== 6'b111011) begin
        n_bad++; $display("[TB] FAIL reset_pins[%0d]: got %b, want 111011", i, {we_n[i], oe_n[i], ce_n[i], rp_n[i], byte_n[i], vpen[i]});
      end
      n_cmp++;
      if ({fa[i], dout[i], err[i], stall[i]} !== 56'h0) begin
        n_bad++; $display("[TB] FAIL reset_regs[%0d]: addr %h data %h err %b stall %b, want all 0", i, fa[i], dout[i], err[i], stall[i]);
      end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rp_n[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL rp_before_edge: got %b, want 0", rp_n[0]); end
    @(posedge clk_bus); #1;
    n_cmp++;
    if (rp_n[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL rp_after_edge: got %b, want 1", rp_n[0]); end
    @(negedge clk_bus);
  endtask

  task automatic test_read();
    int cyc; bit to; logic [31:0] e;
    rexp.push_back(32'hABCD1234);
    start_req(0, 1'b1, 1'b0, 24'h000200, 32'h0);
    wait_done(0, cyc, to);
    n_cmp++;
    if (to || cyc != 7) begin n_bad++; $display("[TB] FAIL read_stall: got %0d cycles (timeout %b), want 7", cyc, to); end
    e = rexp.pop_front();
    n_cmp++;
    if (dout[0] !== e) begin n_bad++; $display("[TB] FAIL read_data: got %h, want %h", dout[0], e); end
    end_req(0);
    @(negedge clk_bus); #1;
    n_cmp++;
    if (stall[0] !== 1'b0 || obs_n != obs_rd) begin
      n_bad++; $display("[TB] FAIL read_idle: stall %b writes %0d, want stall 0 and no writes", stall[0], obs_n - obs_rd);
    end
    @(negedge clk_bus);
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; logic [31:0] e;
    rexp.push_back(32'hABCD1234);
    rexp.push_back(32'hABCD1234);
    start_req(0, 1'b1, 1'b0, 24'h000200, 32'h0);
    wait_done(0, cyc, to);
    e = rexp.pop_front();
    n_cmp++;
    if (to || cyc != 7 || dout[0] !== e) begin
      n_bad++; $display("[TB] FAIL b2b_first: cycles %0d data %h, want 7 and %h", cyc, dout[0], e);
    end
    @(negedge clk_bus);
    wait_done(0, cyc, to);
    e = rexp.pop_front();
    n_cmp++;
    if (to || cyc != 7 || dout[0] !== e) begin
      n_bad++; $display("[TB] FAIL b2b_second: cycles %0d data %h, want 7 and %h", cyc, dout[0], e);
    end
    end_req(0);
    @(negedge clk_bus);
  endtask

  task automatic test_priority();
    int cyc; bit to; logic [31:0] e;
    rexp.push_back(32'hABCD1234);
    start_req(0, 1'b1, 1'b1, 24'h000200, 32'h7777);
    wait_done(0, cyc, to);
    e = rexp.pop_front();
    n_cmp++;
    if (to || cyc != 7 || dout[0] !== e) begin
      n_bad++; $display("[TB] FAIL priority_read: cycles %0d data %h, want 7 and %h", cyc, dout[0], e);
    end
    end_req(0);
    @(negedge clk_bus);
    n_cmp++;
    if (obs_n != obs_rd) begin n_bad++; $display("[TB] FAIL priority_nowrite: got %0d writes, want 0", obs_n - obs_rd); end
  endtask

  task automatic test_program();
    int cyc; bit to; int base; logic [39:0] e, g;
    ready_at[0] = 3; sr_done[0] = 16'h0080;
    base = oefall[0];
    expq.push_back({2'd0, 22'h000101, 16'h0040});
    expq.push_back({2'd0, 22'h000101, 16'h5A5A});
    expq.push_back({2'd0, 22'h000101, 16'h00FF});
    start_req(0, 1'b0, 1'b1, 24'h000202, 32'hDEAD5A5A);
    wait_done(0, cyc, to);
    n_cmp++;
    if (to || cyc != 24) begin n_bad++; $display("[TB] FAIL prog_stall: got %0d cycles (timeout %b), want 24", cyc, to); end
    n_cmp++;
    if (err[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL prog_err: got %b, want 0", err[0]); end
    end_req(0);
    @(negedge clk_bus);
    n_cmp++;
    if (oefall[0] - base != 3) begin n_bad++; $display("[TB] FAIL prog_polls: got %0d, want 3", oefall[0] - base); end
    while (expq.size() > 0) begin
      e = expq.pop_front(); next_obs(g);
      n_cmp++;
      if (g !== e) begin n_bad++; $display("[TB] FAIL prog_write: got %h, want %h", g, e); end
    end
    n_cmp++;
    if (obs_n != obs_rd) begin n_bad++; $display("[TB] FAIL prog_extra: got %0d extra writes, want 0", obs_n - obs_rd); end
  endtask

  task automatic test_prog_error();
    int cyc; bit to; int base; logic [39:0] e, g; logic [31:0] r;
    ready_at[0] = 1; sr_done[0] = 16'h0090;
    base = oefall[0];
    expq.push_back({2'd0, 22'h000102, 16'h0040});
    expq.push_back({2'd0, 22'h000102, 16'h1111});
    expq.push_back({2'd0, 22'h000102, 16'h00FF});
    start_req(0, 1'b0, 1'b1, 24'h000204, 32'h00001111);
    wait_done(0, cyc, to);
    n_cmp++;
    if (to || err[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL perr_done: err %b timeout %b, want err 1", err[0], to); end
    end_req(0);
    @(negedge clk_bus); #1;
    n_cmp++;
    if (err[0] !== 1'b1 || oefall[0] - base != 1) begin
      n_bad++; $display("[TB] FAIL perr_sticky: err %b polls %0d, want 1 and 1", err[0], oefall[0] - base);
    end
    while (expq.size() > 0) begin
      e = expq.pop_front(); next_obs(g);
      n_cmp++;
      if (g !== e) begin n_bad++; $display("[TB] FAIL perr_write: got %h, want %h", g, e); end
    end
    @(negedge clk_bus);
    rexp.push_back(32'h5A5A1234);
    start_req(0, 1'b1, 1'b0, 24'h000200, 32'h0);
    wait_done(0, cyc, to);
    r = rexp.pop_front();
    n_cmp++;
    if (to || dout[0] !== r) begin n_bad++; $display("[TB] FAIL perr_read: got %h, want %h", dout[0], r); end
    n_cmp++;
    if (err[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL perr_clear: got %b, want 0", err[0]); end
    end_req(0);
    @(negedge clk_bus);
  endtask

  task automatic test_timeout();
    int cyc; bit to; int base; logic [39:0] e, g;
    ready_at[1] = 1000; sr_done[1] = 16'h0080;
    base = oefall[1];
    expq.push_back({2'd1, 22'h000101, 16'h0040});
    expq.push_back({2'd1, 22'h000101, 16'h2222});
    expq.push_back({2'd1, 22'h000101, 16'h00FF});
    start_req(1, 1'b0, 1'b1, 24'h000202, 32'h00002222);
    wait_done(1, cyc, to);
    n_cmp++;
    if (to || cyc != 28) begin n_bad++; $display("[TB] FAIL tmo_stall: got %0d cycles (timeout %b), want 28", cyc, to); end
    n_cmp++;
    if (err[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL tmo_err: got %b, want 1", err[1]); end
    end_req(1);
    @(negedge clk_bus);
    n_cmp++;
    if (oefall[1] - base != 4) begin n_bad++; $display("[TB] FAIL tmo_polls: got %0d, want 4", oefall[1] - base); end
    while (expq.size() > 0) begin
      e = expq.pop_front(); next_obs(g);
      n_cmp++;
      if (g !== e) begin n_bad++; $display("[TB] FAIL tmo_write: got %h, want %h", g, e); end
    end
  endtask

  task automatic test_raw_write();
    int cyc; bit to; int base; logic [39:0] e, g;
    base = oefall[2];
    expq.push_back({2'd2, 22'h000180, 16'h00FF});
    start_req(2, 1'b0, 1'b1, 24'h000300, 32'h000000FF);
    wait_done(2, cyc, to);
    n_cmp++;
    if (to || cyc != 5 || err[2] !== 1'b0) begin
      n_bad++; $display("[TB] FAIL raw_done: cycles %0d err %b, want 5 and 0", cyc, err[2]);
    end
    end_req(2);
    @(negedge clk_bus);
    n_cmp++;
    if (oefall[2] - base != 0) begin n_bad++; $display("[TB] FAIL raw_nopoll: got %0d reads, want 0", oefall[2] - base); end
    while (expq.size() > 0) begin
      e = expq.pop_front(); next_obs(g);
      n_cmp++;
      if (g !== e) begin n_bad++; $display("[TB] FAIL raw_write: got %h, want %h", g, e); end
    end
    n_cmp++;
    if (obs_n != obs_rd) begin n_bad++; $display("[TB] FAIL raw_extra: got %0d extra writes, want 0", obs_n - obs_rd); end
  endtask

  task automatic test_reset_midop();
    bit found; logic [39:0] e, g;
    ready_at[0] = 3; sr_done[0] = 16'h0080;
    expq.push_back({2'd0, 22'h000101, 16'h0040});
    start_req(0, 1'b0, 1'b1, 24'h000202, 32'h00005A5A);
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_bus);
      if (pend[0] && !we_n[0]) begin found = 1'b1; break; end
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("[TB] FAIL midop_reach: got no WR_DATA strobe, want one"); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({we_n[0], oe_n[0], ce_n[0], rp_n[0]} !== 4'b1110) begin
      n_bad++; $display("[TB] FAIL midop_pins: got %b, want 1110", {we_n[0], oe_n[0], ce_n[0], rp_n[0]});
    end
    n_cmp++;
    if (fd0 !== 16'hzzzz && fd0 !== 16'h0000) begin n_bad++; $display("[TB] FAIL midop_data: got %h, want released bus", fd0); end
    end_req(0);
    @(negedge clk_bus);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (rp_n[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL midop_rp_hold: got %b, want 0", rp_n[0]); end
    @(posedge clk_bus); #1;
    n_cmp++;
    if (rp_n[0] !== 1'b1 || stall[0] !== 1'b0) begin
      n_bad++; $display("[TB] FAIL midop_rp_release: rp %b stall %b, want 1 and 0", rp_n[0], stall[0]);
    end
    repeat (3) @(negedge clk_bus);
    while (expq.size() > 0) begin
      e = expq.pop_front(); next_obs(g);
      n_cmp++;
      if (g !== e) begin n_bad++; $display("[TB] FAIL midop_write: got %h, want %h", g, e); end
    end
    n_cmp++;
    if (obs_n != obs_rd) begin n_bad++; $display("[TB] FAIL midop_partial: got %0d extra writes, want 0", obs_n - obs_rd); end
  endtask

  task automatic test_strobes();
    n_cmp++;
    if (viol != 0) begin n_bad++; $display("[TB] FAIL strobe_overlap: got %0d cycles with oe_n and we_n low, want 0", viol); end
  endtask

  initial begin
    rst = 1'b1; baddr = '0; bdin = '0;
    n_cmp = 0; n_bad = 0; obs_rd = 0;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; ready_at[i] = 1; sr_done[i] = 16'h0080;
    end
    test_reset();
    test_read();
    test_back_to_back();
    test_priority();
    test_program();
    test_prog_error();
    test_timeout();
    test_raw_write();
    test_reset_midop();
    test_strobes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
